mem_arbiter: RTL

//  Two-master arbiter sharing one single-port synchronous SoC RAM between the core

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter_prio2.sv | 23 ++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : mem_arbiter_pkg
//  Brief   : Shared widths, master ids and arbiter state encoding.
//  Revision: 1.0
// ============================================================================
package mem_arbiter_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef logic master_id_t;
    localparam master_id_t MASTER_D = 1'b0;
    localparam master_id_t MASTER_I = 1'b1;

    localparam int ST_W = 1;
    typedef logic [ST_W-1:0] arb_state_t;
    localparam arb_state_t ST_NORM  = 1'b0;
    localparam arb_state_t ST_BOOST = 1'b1;

    // The counter must be able to hold STARVE_LIMIT itself (saturation value).
    function automatic int starve_cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : mem_arbiter_if
//  Brief   : Bus bundle between the two masters, the arbiter and the RAM.
//  Revision: 1.0
// ============================================================================
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();
    logic              m0_req;
    logic              m0_we;
    logic [AW-1:0]     m0_addr;
    logic [DW-1:0]     m0_wdata;
    logic [DW/8-1:0]   m0_wstrb;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DW-1:0]     m0_rdata;

    logic              m1_req;
    logic [AW-1:0]     m1_addr;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DW-1:0]     m1_rdata;

    logic              mem_en;
    logic [DW/8-1:0]   mem_we;
    logic [AW-3:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_addr,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_addr,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter_prio2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : mem_arbiter_prio2
//  Brief   : Two-way fixed-priority pick (req0 first) with boost override for req1.
//  Revision: 1.0
// ============================================================================
module mem_arbiter_prio2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_boost,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic w_pick1;

    assign w_pick1 = i_req1 & (i_boost | ~i_req0);
    assign o_gnt1  = w_pick1;
    assign o_gnt0  = i_req0 & ~w_pick1;

endmodule : mem_arbiter_prio2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : mem_arbiter
//  Brief   : Data/fetch arbiter for a single-port 1-cycle-latency RAM.
//  Revision: 1.0
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    localparam int             CW         = starve_cnt_width(STARVE_LIMIT);
    localparam int             SW         = DW / 8;
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(STARVE_LIMIT - 1);
    localparam logic [CW-1:0]  C_CNT_MAX  = CW'(STARVE_LIMIT);

    arb_state_t     r_state;
    arb_state_t     w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;

    logic           r_own_vld;
    master_id_t     r_own_id;
    logic [DW-1:0]  r_m0_rdata;
    logic [DW-1:0]  r_m1_rdata;

    logic           w_req0;
    logic           w_req1;
    logic           w_boost;
    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_rd_gnt;
    logic           w_rv0;
    logic           w_rv1;

    logic           w_mem_en;
    logic [SW-1:0]  w_mem_we;
    logic [AW-3:0]  w_mem_addr;
    logic [DW-1:0]  w_mem_wdata;
    logic           w_unused_addr_lsbs;

    // Grants are combinational, so they are masked while reset is held.
    assign w_req0  = bus.m0_req & rst_n;
    assign w_req1  = bus.m1_req & rst_n;
    assign w_boost = (r_state == ST_BOOST);

    mem_arbiter_prio2 u_prio (
        .i_req0  (w_req0),
        .i_req1  (w_req1),
        .i_boost (w_boost),
        .o_gnt0  (w_gnt0),
        .o_gnt1  (w_gnt1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_NORM;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_NORM: begin
                if (w_req1 && w_gnt0) begin
                    if (r_cnt == C_CNT_LAST) begin
                        w_state_nxt = ST_BOOST;
                    end
                    if (r_cnt != C_CNT_MAX) begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ST_BOOST: begin
                // Either m1 is served now or it withdrew; both end the boost.
                w_state_nxt = ST_NORM;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = ST_NORM;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_mem_en    = w_gnt0 | w_gnt1;
        w_mem_we    = '0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_gnt1) begin
            w_mem_addr = bus.m1_addr[AW-1:2];
        end else if (w_gnt0) begin
            w_mem_addr  = bus.m0_addr[AW-1:2];
            w_mem_wdata = bus.m0_wdata;
            if (bus.m0_we) begin
                w_mem_we = bus.m0_wstrb;
            end
        end
    end

    assign w_rd_gnt = w_gnt1 | (w_gnt0 & ~bus.m0_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_own_vld <= 1'b0;
            r_own_id  <= MASTER_D;
        end else begin
            r_own_vld <= w_rd_gnt;
            r_own_id  <= w_gnt1 ? MASTER_I : MASTER_D;
        end
    end

    assign w_rv0 = r_own_vld & (r_own_id == MASTER_D);
    assign w_rv1 = r_own_vld & (r_own_id == MASTER_I);

    // RAM data passes straight through on the owner's rvalid cycle and is held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            if (w_rv0) begin
                r_m0_rdata <= bus.mem_rdata;
            end
            if (w_rv1) begin
                r_m1_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.m0_rvalid = w_rv0;
    assign bus.m1_rvalid = w_rv1;
    assign bus.m0_rdata  = w_rv0 ? bus.mem_rdata : r_m0_rdata;
    assign bus.m1_rdata  = w_rv1 ? bus.mem_rdata : r_m1_rdata;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    assign w_unused_addr_lsbs = ^{bus.m0_addr[1:0], bus.m1_addr[1:0]};

endmodule : mem_arbiter
`default_nettype wire
